// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit PRBS generator/checker pair.
// Holds the LFSR length, the tap mask for x^4+x^3+1, the one-step
// advance function and the checker FSM state encoding.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 4;
  // Taps on q[3] and q[2]: feedback = q[3] ^ q[2].
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 4'b1100;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Feedback bit for a given register; this is also the transmitted bit.
  function automatic logic lfsr_fb(input logic [LFSR_WIDTH-1:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

  // One generator step: shift left, feedback into the LSB.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] q);
    return {q[LFSR_WIDTH-2:0], lfsr_fb(q)};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, reset (async active-low), inc (count enable),
//        clr (sync clear, wins over inc), count (current value).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    count <= '0;
    else if (clr)                  count <= '0;
    else if (inc && count != '1)   count <= count + 1'b1;
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker for the 4-bit x^4+x^3+1 generator.
// Self-synchronises a local LFSR copy to the serial stream, then
// free-runs it and flags/counts mismatching bits.
// Ports:
//   clk, reset (async active-low)
//   data_in, data_valid   received bit and its qualifier
//   clear_counts          sync clear of both counters
//   locked                high while in LOCKED
//   err_pulse             one-cycle pulse per errored bit while locked
//   err_count, bit_count  saturating error / checked-bit counters
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int LOCK_THRESH = 8,
  parameter int LOSS_THRESH = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic             clear_counts,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_THRESH + 1);
  localparam int RW = $clog2(LOSS_THRESH + 1);

  chk_state_t       state, state_nx;
  logic [WIDTH-1:0] r, r_nx;
  logic [FW-1:0]    fill_cnt, fill_nx;
  logic [MW-1:0]    match_cnt, match_nx;
  logic [RW-1:0]    err_run, err_run_nx;
  logic             err_inc, bit_inc;
  logic             miss;

  // Prediction comes from the pre-shift register contents.
  assign miss = data_in != lfsr_fb(r);

  always_comb begin
    state_nx   = state;
    r_nx       = r;
    fill_nx    = fill_cnt;
    match_nx   = match_cnt;
    err_run_nx = err_run;
    err_inc    = 1'b0;
    bit_inc    = 1'b0;
    if (data_valid) begin
      unique case (state)
        SEARCH: begin
          r_nx    = {r[WIDTH-2:0], data_in};
          fill_nx = fill_cnt + 1'b1;
          if (fill_cnt == FW'(WIDTH - 1)) begin
            state_nx = VERIFY;
            fill_nx  = '0;
            match_nx = '0;
          end
        end
        VERIFY: begin
          r_nx = {r[WIDTH-2:0], data_in};
          // An all-zero register predicts zeros forever; a dead line
          // would otherwise verify cleanly, so treat it as a miss.
          if (miss || r == '0) begin
            state_nx = SEARCH;
            fill_nx  = '0;
          end else begin
            match_nx = match_cnt + 1'b1;
            if (match_cnt == MW'(LOCK_THRESH - 1)) begin
              state_nx   = LOCKED;
              err_run_nx = '0;
            end
          end
        end
        LOCKED: begin
          // Free-running: a flipped bit on the line does not corrupt r.
          r_nx    = lfsr_next(r);
          bit_inc = 1'b1;
          if (miss) begin
            err_inc    = 1'b1;
            err_run_nx = err_run + 1'b1;
            if (err_run == RW'(LOSS_THRESH - 1)) begin
              state_nx   = SEARCH;
              fill_nx    = '0;
              err_run_nx = '0;
            end
          end else begin
            err_run_nx = '0;
          end
        end
        default: begin
          state_nx = SEARCH;
          fill_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      r         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      err_run   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nx;
      r         <= r_nx;
      fill_cnt  <= fill_nx;
      match_cnt <= match_nx;
      err_run   <= err_run_nx;
      locked    <= state_nx == LOCKED;
      err_pulse <= err_inc;
    end
  end

  // [0] = errors, [1] = checked bits
  logic [1:0]            cnt_inc;
  logic [1:0][CNT_W-1:0] cnt;

  assign cnt_inc = {bit_inc, err_inc};

  for (genvar i = 0; i < 2; i++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (cnt_inc[i]),
      .clr   (clear_counts),
      .count (cnt[i])
    );
  end

  assign err_count = cnt[0];
  assign bit_count = cnt[1];

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: clean lock, single error, loss and
// relock, counter clear, idle cycles, async reset, sparse valid, dead line.
// A second instance with 4-bit counters shares the stimulus to exercise
// saturation.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset, data_in, data_valid, clear_counts;
  logic        locked, err_pulse;
  logic [15:0] err_count, bit_count;
  logic        locked_s, err_pulse_s;
  logic [3:0]  err_count_s, bit_count_s;

  int          n_chk = 0;
  int          n_fail = 0;
  int          pulse_cnt = 0;
  logic [3:0]  g = 4'b0001;
  logic        b;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .clear_counts(clear_counts), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .bit_count(bit_count)
  );

  lfsr_checker #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .clear_counts(clear_counts), .locked(locked_s), .err_pulse(err_pulse_s),
    .err_count(err_count_s), .bit_count(bit_count_s)
  );

  always @(negedge clk) if (err_pulse === 1'b1) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference generator: bit = q3^q2, q <= {q[2:0], bit}.
  task automatic next_bit(output logic bo);
    bo = g[3] ^ g[2];
    g  = {g[2:0], bo};
  endtask

  // Present inputs, take one rising edge, land 1 time unit after it.
  task automatic drive(input logic d, input logic v, input logic clr);
    data_in      = d;
    data_valid   = v;
    clear_counts = clr;
    @(posedge clk);
    #1;
    data_valid   = 1'b0;
    clear_counts = 1'b0;
  endtask

  task automatic send_clean(input int n);
    logic x;
    for (int i = 0; i < n; i++) begin
      next_bit(x);
      drive(x, 1'b1, 1'b0);
    end
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; data_in = 1'b0; data_valid = 1'b0; clear_counts = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_pulse", err_pulse, 0);
    check("rst_err", err_count, 0);
    check("rst_bits", bit_count, 0);
    @(negedge clk);
    reset = 1'b1;

    // Clean lock: 4 fill + 8 verify
    send_clean(11);
    check("lock_11", locked, 0);
    send_clean(1);
    check("lock_12", locked, 1);
    send_clean(28);
    check("clean_err", err_count, 0);
    check("clean_bits", bit_count, 28);
    check("sat_bits", bit_count_s, 15);
    check("clean_pulses", pulse_cnt, 0);

    // clear_counts beats the same-cycle increment, FSM untouched
    next_bit(b); drive(b, 1'b1, 1'b1);
    check("clr_bits", bit_count, 0);
    check("clr_locked", locked, 1);

    // Single flipped bit
    next_bit(b); drive(~b, 1'b1, 1'b0);
    check("single_pulse", err_pulse, 1);
    check("single_err", err_count, 1);
    send_clean(1);
    check("single_pulse_off", err_pulse, 0);
    send_clean(9);
    check("single_err_hold", err_count, 1);
    check("single_bits", bit_count, 11);
    check("single_locked", locked, 1);

    // Four consecutive errors drop lock on the 4th
    for (int i = 0; i < 3; i++) begin
      next_bit(b); drive(~b, 1'b1, 1'b0);
    end
    check("run3_locked", locked, 1);
    check("run3_err", err_count, 4);
    next_bit(b); drive(~b, 1'b1, 1'b0);
    check("run4_locked", locked, 0);
    check("run4_err", err_count, 5);
    check("run4_pulse", err_pulse, 1);
    send_clean(11);
    check("relock_11", locked, 0);
    send_clean(1);
    check("relock_12", locked, 1);
    check("relock_bits", bit_count, 15);

    // Clear on the same cycle as an errored bit
    next_bit(b); drive(~b, 1'b1, 1'b1);
    check("clr_err_cnt", err_count, 0);
    check("clr_err_bits", bit_count, 0);
    check("clr_err_pulse", err_pulse, 1);
    check("clr_err_locked", locked, 1);

    // Idle cycles hold everything, data ignored
    for (int i = 0; i < 5; i++) drive(i[0], 1'b0, 1'b0);
    check("idle_bits", bit_count, 0);
    check("idle_locked", locked, 1);
    send_clean(3);
    check("idle_resume_bits", bit_count, 3);
    check("idle_resume_err", err_count, 0);
    check("pulses_total", pulse_cnt, 6);

    // Async reset mid-stream clears outputs without an edge
    send_clean(2);
    #2 reset = 1'b0;
    #1;
    check("arst_locked", locked, 0);
    check("arst_bits", bit_count, 0);
    check("arst_err", err_count, 0);
    @(negedge clk);
    reset = 1'b1;
    send_clean(11);
    check("arst_relock_11", locked, 0);
    send_clean(1);
    check("arst_relock_12", locked, 1);

    // Valid every other cycle, inverted junk on idle cycles
    pulse_reset();
    for (int i = 0; i < 11; i++) begin
      next_bit(b); drive(b, 1'b1, 1'b0);
      drive(~b, 1'b0, 1'b0);
    end
    check("sparse_22cyc", locked, 0);
    next_bit(b); drive(b, 1'b1, 1'b0);
    check("sparse_23cyc", locked, 1);
    for (int i = 0; i < 10; i++) begin
      next_bit(b); drive(b, 1'b1, 1'b0);
      drive(~b, 1'b0, 1'b0);
    end
    check("sparse_err", err_count, 0);
    check("sparse_bits", bit_count, 10);

    // Dead line never locks
    pulse_reset();
    for (int i = 0; i < 50; i++) drive(1'b0, 1'b1, 1'b0);
    check("dead_locked", locked, 0);
    check("dead_bits", bit_count, 0);
    check("dead_err", err_count, 0);
    check("dead_pulses", pulse_cnt, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
